xnorpop_stream_tx: RTL and testbench
====================================

XNORPOP_STREAM_TX -- requirements
Module: xnorpop_stream_tx

Interface
REQ-001 SHALL have parameter pop_size, default 576, meaning bits per frame (minimum 2).
REQ-002 SHALL have parameter cnt_width, default $clog2(pop_size+1), meaning width of bit counter and reference popcount.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port in_valid  input  1  parallel frame offered.
REQ-006 SHALL have port in_ready  output  1  frame accepted when in_valid & in_ready at rising edge.
REQ-007 SHALL have port a_vec  input  pop_size  activation frame.
REQ-008 SHALL have port w_vec  input  pop_size  weight frame.
REQ-009 SHALL have port a  output  1  serial activation bit, registered.
REQ-010 SHALL have port w  output  1  serial weight bit, registered.
REQ-011 SHALL have port bit_valid  output  1  a/w carry frame data this cycle.
REQ-012 SHALL have port frame_last  output  1  current bit is final bit of frame.
REQ-013 SHALL have port busy  output  1  state is SEND.
REQ-014 SHALL have ports ref_pop  output  cnt_width  and ref_pop_valid  output  1, present only with XNORPOP_TX_REFPOP_EN.

Function
REQ-015 SHALL implement states IDLE and SEND; IDLE->SEND on accept; SEND->IDLE after final bit unless a new frame is accepted that cycle (SEND->SEND).
REQ-016 SHALL drive in_ready = 1 in IDLE, and in SEND only during the cycle frame_last = 1; 0 otherwise.
REQ-017 SHALL capture a_vec and w_vec into internal shift registers on accept; inputs are ignored at all other times.
REQ-018 SHALL present the first bit (a_vec[pop_size-1], w_vec[pop_size-1]) in the cycle after accept, then one bit per cycle MSB first down to index 0; a receiver shifting in at LSB holds the original vectors after pop_size shifts.
REQ-019 SHALL hold bit_valid = 1 for exactly pop_size consecutive cycles per frame, with no bubbles.
REQ-020 SHALL assert frame_last only with bit index 0, for exactly one cycle per frame.
REQ-021 SHALL stream back-to-back frames gaplessly: a frame accepted during frame_last starts its first bit in the next cycle.
REQ-022 SHALL drive a = 0, w = 0, bit_valid = 0, frame_last = 0 whenever no frame bit is presented.
REQ-023 SHALL use a bit counter of cnt_width bits counting 0..pop_size-1 that never wraps past pop_size-1.

Reset
REQ-024 SHALL, on any rising edge with reset = 0, enter IDLE and clear counter, shift registers, a, w, bit_valid, frame_last, busy, ref_pop and ref_pop_valid to 0 in the following cycle.
REQ-025 SHALL abort a frame in progress on reset, with no frame_last or ref_pop_valid for the aborted frame.
REQ-026 SHALL drive in_ready = 0 while reset = 0, and 1 from the first cycle after reset is released.

Configuration
REQ-027 SHALL, with macro XNORPOP_TX_REFPOP_EN defined, accumulate popcount of XNOR(a, w) over the frame bits. ref_pop SHALL present the frame total and ref_pop_valid SHALL pulse for one cycle, in the cycle after frame_last. The accumulator SHALL restart at the next frame's first bit. Range is 0..pop_size.
REQ-028 SHALL, without XNORPOP_TX_REFPOP_EN, omit ref_pop, ref_pop_valid and the accumulator entirely; all other behaviour SHALL be identical.

Verification (pop_size = 8 unless stated)
REQ-029 SHALL check single frame: a_vec = 8'hA5, w_vec = 8'h0F accepted at cycle 0 -> a = 1,0,1,0,0,1,0,1 and w = 0,0,0,0,1,1,1,1 on cycles 1-8; frame_last on cycle 8; in_ready = 1 again on cycle 8.
REQ-030 SHALL check back-to-back: second frame a_vec = 8'hFF offered during frame_last -> accepted, a = 1 on cycles 9-16, bit_valid continuous over cycles 1-16.
REQ-031 SHALL check backpressure: in_valid held with 8'h3C while busy -> in_ready = 0 and no capture until frame_last; a changed a_vec mid-frame does not alter the serial output.
REQ-032 SHALL check mid-frame reset: reset = 0 at bit 4 -> outputs 0 next cycle, no frame_last, in_ready = 1 after release, and a fresh frame streams correctly.
REQ-033 SHALL check the REFPOP build: 8'hA5 / 8'h0F -> ref_pop = 4 with a one-cycle ref_pop_valid on cycle 9; equal vectors 8'h5A / 8'h5A -> ref_pop = 8.
REQ-034 SHALL check a loop-back, with pop_size = 576 and XNORPOP_TX_REFPOP_EN: a random frame is fed through a serial-in XNOR-popcount receiver; the receiver's pop equals ref_pop.

Source files
------------

// File: rtl/xnorpop_stream_tx.sv
// xnorpop_stream_tx: serialises parallel activation/weight frames, MSB first, one bit pair per cycle.
// Defining XNORPOP_TX_REFPOP_EN adds a reference XNOR-popcount of each transmitted frame.
module xnorpop_stream_tx #(
  parameter int pop_size  = 576,
  parameter int cnt_width = $clog2(pop_size + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [pop_size-1:0]  a_vec,
  input  logic [pop_size-1:0]  w_vec,
  output logic                 a,
  output logic                 w,
  output logic                 bit_valid,
  output logic                 frame_last,
  output logic                 busy
`ifdef XNORPOP_TX_REFPOP_EN
  ,
  output logic [cnt_width-1:0] ref_pop,
  output logic                 ref_pop_valid
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [cnt_width-1:0] LAST_IDX = cnt_width'(pop_size - 1);

  state_t               state_r, state_s;
  logic                 load_s, shift_s, accept_s;
  logic [pop_size-1:0]  a_sr_r, a_sr_s, w_sr_r, w_sr_s;
  logic [cnt_width-1:0] cnt_r, cnt_s;
  logic                 a_r, a_s, w_r, w_s;
  logic                 bit_valid_r, bit_valid_s, frame_last_r, frame_last_s;

  // A new frame can only be taken while idle or while the last bit is on the wire.
  assign in_ready   = reset & ((state_r == IDLE) | frame_last_r);
  assign accept_s   = in_valid & in_ready;
  assign busy       = (state_r == SEND);
  assign a          = a_r;
  assign w          = w_r;
  assign bit_valid  = bit_valid_r;
  assign frame_last = frame_last_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: decides whether this edge loads a new frame or shifts the current one.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SEND;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (frame_last_r) begin
          if (accept_s) begin
            state_s = SEND;
            load_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = SEND;
          shift_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath next values; the MSB goes straight to the output flop, the rest waits in the shifter.
  always_comb begin
    a_sr_s       = a_sr_r;
    w_sr_s       = w_sr_r;
    cnt_s        = cnt_r;
    a_s          = 1'b0;
    w_s          = 1'b0;
    bit_valid_s  = 1'b0;
    frame_last_s = 1'b0;
    if (load_s) begin
      a_s          = a_vec[pop_size-1];
      w_s          = w_vec[pop_size-1];
      a_sr_s       = {a_vec[pop_size-2:0], 1'b0};
      w_sr_s       = {w_vec[pop_size-2:0], 1'b0};
      cnt_s        = {cnt_width{1'b0}};
      bit_valid_s  = 1'b1;
      frame_last_s = 1'b0;
    end else if (shift_s) begin
      a_s          = a_sr_r[pop_size-1];
      w_s          = w_sr_r[pop_size-1];
      a_sr_s       = {a_sr_r[pop_size-2:0], 1'b0};
      w_sr_s       = {w_sr_r[pop_size-2:0], 1'b0};
      cnt_s        = cnt_r + cnt_width'(1);
      bit_valid_s  = 1'b1;
      frame_last_s = ((cnt_r + cnt_width'(1)) == LAST_IDX);
    end else begin
      cnt_s = {cnt_width{1'b0}};
    end
  end

  // Shift registers, bit counter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sr_r       <= {pop_size{1'b0}};
      w_sr_r       <= {pop_size{1'b0}};
      cnt_r        <= {cnt_width{1'b0}};
      a_r          <= 1'b0;
      w_r          <= 1'b0;
      bit_valid_r  <= 1'b0;
      frame_last_r <= 1'b0;
    end else begin
      a_sr_r       <= a_sr_s;
      w_sr_r       <= w_sr_s;
      cnt_r        <= cnt_s;
      a_r          <= a_s;
      w_r          <= w_s;
      bit_valid_r  <= bit_valid_s;
      frame_last_r <= frame_last_s;
    end
  end

`ifdef XNORPOP_TX_REFPOP_EN
  function automatic logic xnor_bit(input logic x, input logic y);
    return ~(x ^ y);
  endfunction

  logic [cnt_width-1:0] acc_r, acc_sum_s, ref_pop_r;
  logic                 ref_pop_valid_r;

  // Running total including the bit on the wire; the first bit of a frame restarts it.
  always_comb begin
    acc_sum_s = {cnt_width{1'b0}};
    if (bit_valid_r && (cnt_r == {cnt_width{1'b0}})) begin
      acc_sum_s = cnt_width'(xnor_bit(a_r, w_r));
    end else begin
      acc_sum_s = acc_r + cnt_width'(xnor_bit(a_r, w_r));
    end
  end

  // Accumulator and frame-total result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r           <= {cnt_width{1'b0}};
      ref_pop_r       <= {cnt_width{1'b0}};
      ref_pop_valid_r <= 1'b0;
    end else begin
      if (bit_valid_r) begin
        acc_r <= acc_sum_s;
      end else begin
        acc_r <= acc_r;
      end
      if (frame_last_r) begin
        ref_pop_r       <= acc_sum_s;
        ref_pop_valid_r <= 1'b1;
      end else begin
        ref_pop_r       <= ref_pop_r;
        ref_pop_valid_r <= 1'b0;
      end
    end
  end

  assign ref_pop       = ref_pop_r;
  assign ref_pop_valid = ref_pop_valid_r;
`endif

endmodule

// File: tb/tb_xnorpop_stream_tx.sv
// Bench for xnorpop_stream_tx: directed vector table, hand sequences, and random frames
// checked by serial-in receiver scoreboards on an 8-bit and a 576-bit instance.
module tb_xnorpop_stream_tx;

  localparam int P8 = 8;
  localparam int PL = 576;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- 8-bit instance ----------------
  logic          reset8, in_valid8, in_ready8, a8, w8, bit_valid8, frame_last8, busy8;
  logic [P8-1:0] a_vec8, w_vec8;
`ifdef XNORPOP_TX_REFPOP_EN
  logic [3:0]    ref_pop8;
  logic          ref_pop_valid8;
`endif

  xnorpop_stream_tx #(.pop_size(P8)) dut8 (
    .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_vec(a_vec8), .w_vec(w_vec8), .a(a8), .w(w8), .bit_valid(bit_valid8),
    .frame_last(frame_last8), .busy(busy8)
`ifdef XNORPOP_TX_REFPOP_EN
    , .ref_pop(ref_pop8), .ref_pop_valid(ref_pop_valid8)
`endif
  );

  // ---------------- 576-bit instance ----------------
  logic          resetL, in_validL, in_readyL, aL, wL, bit_validL, frame_lastL, busyL;
  logic [PL-1:0] a_vecL, w_vecL;
`ifdef XNORPOP_TX_REFPOP_EN
  logic [9:0]    ref_popL;
  logic          ref_pop_validL;
`endif

  xnorpop_stream_tx #(.pop_size(PL)) dutL (
    .clk(clk), .reset(resetL), .in_valid(in_validL), .in_ready(in_readyL),
    .a_vec(a_vecL), .w_vec(w_vecL), .a(aL), .w(wL), .bit_valid(bit_validL),
    .frame_last(frame_lastL), .busy(busyL)
`ifdef XNORPOP_TX_REFPOP_EN
    , .ref_pop(ref_popL), .ref_pop_valid(ref_pop_validL)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- receiver scoreboard, 8-bit ----------------
  logic [15:0]   q8[$];
  logic [P8-1:0] rx_a8, rx_w8;
  int            rx_n8 = 0;
`ifdef XNORPOP_TX_REFPOP_EN
  logic          pend8 = 1'b0;
  int            pend_val8 = 0;
`endif

  always @(negedge clk) begin
    if (!reset8) begin
      q8.delete();
      rx_n8 = 0;
`ifdef XNORPOP_TX_REFPOP_EN
      pend8 = 1'b0;
`endif
    end else begin
`ifdef XNORPOP_TX_REFPOP_EN
      if (pend8 || ref_pop_valid8) begin
        check("m8_refpop_valid", 32'(ref_pop_valid8), 32'(pend8));
        check("m8_refpop", 32'(ref_pop8), 32'(pend_val8));
        pend8 = 1'b0;
      end
`endif
      if (bit_valid8) begin
        rx_a8 = {rx_a8[P8-2:0], a8};
        rx_w8 = {rx_w8[P8-2:0], w8};
        rx_n8++;
        if (frame_last8) begin
          logic [15:0] e;
          check("m8_bitcount", 32'(rx_n8), 32'(P8));
          if (q8.size() == 0) begin
            check("m8_unexpected_frame", 32'(1), 32'(0));
          end else begin
            e = q8.pop_front();
            check("m8_a_frame", 32'(rx_a8), 32'(e[15:8]));
            check("m8_w_frame", 32'(rx_w8), 32'(e[7:0]));
`ifdef XNORPOP_TX_REFPOP_EN
            pend8     = 1'b1;
            pend_val8 = $countones(~(e[15:8] ^ e[7:0]));
`endif
          end
          rx_n8 = 0;
        end
      end else begin
        check("m8_idle", 32'({a8, w8, frame_last8, busy8, (rx_n8 != 0)}), 32'(0));
      end
      if (in_valid8 && in_ready8) q8.push_back({a_vec8, w_vec8});
    end
  end

  // ---------------- receiver scoreboard, 576-bit ----------------
  logic [2*PL-1:0] qL[$];
  logic [PL-1:0]   rx_aL, rx_wL;
  int              rx_nL = 0;
  int              rx_popL = 0;
`ifdef XNORPOP_TX_REFPOP_EN
  logic            pendL = 1'b0;
  int              pend_valL = 0;
`endif

  always @(negedge clk) begin
    if (!resetL) begin
      qL.delete();
      rx_nL   = 0;
      rx_popL = 0;
`ifdef XNORPOP_TX_REFPOP_EN
      pendL = 1'b0;
`endif
    end else begin
`ifdef XNORPOP_TX_REFPOP_EN
      if (pendL || ref_pop_validL) begin
        check("mL_refpop_valid", 32'(ref_pop_validL), 32'(pendL));
        check("mL_refpop_vs_receiver", 32'(ref_popL), 32'(pend_valL));
        pendL = 1'b0;
      end
`endif
      if (bit_validL) begin
        rx_aL = {rx_aL[PL-2:0], aL};
        rx_wL = {rx_wL[PL-2:0], wL};
        if (aL == wL) rx_popL++;
        rx_nL++;
        if (frame_lastL) begin
          logic [2*PL-1:0] e;
          check("mL_bitcount", 32'(rx_nL), 32'(PL));
          if (qL.size() == 0) begin
            check("mL_unexpected_frame", 32'(1), 32'(0));
          end else begin
            e = qL.pop_front();
            check("mL_a_frame", 32'(rx_aL == e[2*PL-1:PL]), 32'(1));
            check("mL_w_frame", 32'(rx_wL == e[PL-1:0]), 32'(1));
            check("mL_pop_model", 32'(rx_popL), 32'($countones(~(e[2*PL-1:PL] ^ e[PL-1:0]))));
`ifdef XNORPOP_TX_REFPOP_EN
            pendL     = 1'b1;
            pend_valL = rx_popL;
`endif
          end
          rx_nL   = 0;
          rx_popL = 0;
        end
      end else begin
        check("mL_idle", 32'({aL, wL, frame_lastL, busyL, (rx_nL != 0)}), 32'(0));
      end
      if (in_validL && in_readyL) qL.push_back({a_vecL, w_vecL});
    end
  end

  // ---------------- drivers ----------------
  task automatic send8(input logic [7:0] av, input logic [7:0] wv);
    int t = 0;
    in_valid8 = 1'b1; a_vec8 = av; w_vec8 = wv;
    @(negedge clk);
    while (!in_ready8 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("send8_timeout", 32'(1), 32'(0));
    @(posedge clk); #1;
    in_valid8 = 1'b0; a_vec8 = 8'($urandom); w_vec8 = 8'($urandom);
  endtask

  task automatic sendL(input logic [PL-1:0] av, input logic [PL-1:0] wv);
    int t = 0;
    in_validL = 1'b1; a_vecL = av; w_vecL = wv;
    @(negedge clk);
    while (!in_readyL && t < 1200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1200) check("sendL_timeout", 32'(1), 32'(0));
    @(posedge clk); #1;
    in_validL = 1'b0;
  endtask

  function automatic logic [PL-1:0] rand_vec();
    logic [PL-1:0] v;
    for (int i = 0; i < PL / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       vin;
    logic [7:0] av;
    logic [7:0] wv;
    logic [5:0] eo;   // {a, w, bit_valid, frame_last, in_ready, busy}
    logic       rpv;
    logic [3:0] rp;
  } row_t;

  row_t tbl[18];

  function automatic row_t mk(input logic vin, input logic [7:0] av, input logic [7:0] wv,
                              input logic [5:0] eo, input logic rpv, input logic [3:0] rp);
    row_t r;
    r.vin = vin; r.av = av; r.wv = wv; r.eo = eo; r.rpv = rpv; r.rp = rp;
    return r;
  endfunction

  initial begin
    logic [7:0] f1a, f1w, f2, fa, fw, fq;
    logic [PL-1:0] va;

    tbl[0]  = mk(1'b1, 8'hA5, 8'h0F, 6'b000010, 1'b0, 4'd0);
    tbl[1]  = mk(1'b0, 8'h00, 8'h00, 6'b101001, 1'b0, 4'd0);
    tbl[2]  = mk(1'b0, 8'h00, 8'h00, 6'b001001, 1'b0, 4'd0);
    tbl[3]  = mk(1'b0, 8'h00, 8'h00, 6'b101001, 1'b0, 4'd0);
    tbl[4]  = mk(1'b0, 8'h00, 8'h00, 6'b001001, 1'b0, 4'd0);
    tbl[5]  = mk(1'b0, 8'h00, 8'h00, 6'b011001, 1'b0, 4'd0);
    tbl[6]  = mk(1'b0, 8'h00, 8'h00, 6'b111001, 1'b0, 4'd0);
    tbl[7]  = mk(1'b0, 8'h00, 8'h00, 6'b011001, 1'b0, 4'd0);
    tbl[8]  = mk(1'b1, 8'hFF, 8'h00, 6'b111111, 1'b0, 4'd0);
    tbl[9]  = mk(1'b0, 8'h3C, 8'hC3, 6'b101001, 1'b1, 4'd4);
    for (int i = 10; i < 16; i++) tbl[i] = mk(1'b0, 8'h3C, 8'hC3, 6'b101001, 1'b0, 4'd0);
    tbl[16] = mk(1'b0, 8'h00, 8'h00, 6'b101111, 1'b0, 4'd0);
    tbl[17] = mk(1'b0, 8'h00, 8'h00, 6'b000010, 1'b1, 4'd0);

    reset8 = 1'b0; in_valid8 = 1'b0; a_vec8 = 8'h00; w_vec8 = 8'h00;
    resetL = 1'b0; in_validL = 1'b0; a_vecL = '0; w_vecL = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({a8, w8, bit_valid8, frame_last8, in_ready8, busy8}), 32'(0));
    @(posedge clk); #1; reset8 = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready8), 32'(1));

    // single frame followed by a back-to-back frame
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      in_valid8 = tbl[i].vin; a_vec8 = tbl[i].av; w_vec8 = tbl[i].wv;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'({a8, w8, bit_valid8, frame_last8, in_ready8, busy8}), 32'(tbl[i].eo));
`ifdef XNORPOP_TX_REFPOP_EN
      check($sformatf("vec%0d_rpv", i), 32'(ref_pop_valid8), 32'(tbl[i].rpv));
      if (tbl[i].rpv) check($sformatf("vec%0d_rp", i), 32'(ref_pop8), 32'(tbl[i].rp));
`endif
    end

    // backpressure: new frame held while busy, mid-frame input change ignored
    f1a = 8'h96; f1w = 8'h69; f2 = 8'h3C;
    @(posedge clk); #1; in_valid8 = 1'b1; a_vec8 = f1a; w_vec8 = f1w;
    @(negedge clk); check("bp_ready_idle", 32'(in_ready8), 32'(1));
    @(posedge clk); #1; a_vec8 = f2; w_vec8 = f2;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 4) a_vec8 = 8'hC3;
      if (c == 6) a_vec8 = f2;
      @(negedge clk);
      check("bp_ready", 32'(in_ready8), 32'(c == 8));
      check("bp_a", 32'(a8), 32'(f1a[8-c]));
      check("bp_w", 32'(w8), 32'(f1w[8-c]));
    end
    @(posedge clk); #1; in_valid8 = 1'b0; a_vec8 = 8'hFF; w_vec8 = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check("bp2_a", 32'(a8), 32'(f2[8-c]));
      check("bp2_w", 32'(w8), 32'(f2[8-c]));
      check("bp2_last", 32'(frame_last8), 32'(c == 8));
    end

    // reset in the middle of a frame
    @(posedge clk); #1; in_valid8 = 1'b1; a_vec8 = 8'hA5; w_vec8 = 8'h0F;
    @(posedge clk); #1; in_valid8 = 1'b0;
    fa = 8'hA5;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 4) reset8 = 1'b0;
      @(negedge clk);
      if (c < 4) check("rst_pre_a", 32'(a8), 32'(fa[8-c]));
      else       check("rst_ready_low", 32'(in_ready8), 32'(0));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_outputs", 32'({a8, w8, bit_valid8, frame_last8, in_ready8, busy8}), 32'(0));
`ifdef XNORPOP_TX_REFPOP_EN
    check("rst_refpop", 32'({ref_pop_valid8, ref_pop8}), 32'(0));
`endif
    @(posedge clk); #1; reset8 = 1'b1;
    @(negedge clk);
    check("rst_release", 32'({frame_last8, bit_valid8, in_ready8}), 32'(3'b001));
`ifdef XNORPOP_TX_REFPOP_EN
    check("rst_no_refpop", 32'(ref_pop_valid8), 32'(0));
`endif
    fq = 8'h5A;
    @(posedge clk); #1; in_valid8 = 1'b1; a_vec8 = fq; w_vec8 = fq;
    @(posedge clk); #1; in_valid8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check("fresh_aw", 32'({a8, w8}), 32'({fq[8-c], fq[8-c]}));
      check("fresh_last", 32'(frame_last8), 32'(c == 8));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("fresh_done", 32'(bit_valid8), 32'(0));
`ifdef XNORPOP_TX_REFPOP_EN
    check("fresh_refpop", 32'({ref_pop_valid8, ref_pop8}), 32'({1'b1, 4'd8}));
`endif

    // random frames with random gaps
    for (int n = 0; n < 40; n++) begin
      fa = 8'($urandom); fw = 8'($urandom);
      if (n % 7 == 0) fw = fa;
      send8(fa, fw);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain8", 32'(q8.size()), 32'(0));

    // 576-bit loop-back
    @(posedge clk); #1; resetL = 1'b1;
    @(negedge clk); check("L_ready", 32'(in_readyL), 32'(1));
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) begin
      va = rand_vec();
      case (n)
        1:       sendL(va, va);
        2:       sendL(va, ~va);
        default: sendL(va, rand_vec());
      endcase
    end
    for (int t = 0; t < 1300 && qL.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drainL", 32'(qL.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
